// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP-1 controller-sequencer: T1..T6 ring, control word, halt latch
//
// Purpose: steps a six-state one-hot ring (T1..T6) and combines it with the
// instruction decoder one-hots to produce the per-cycle control strobes for
// PC, MAR, RAM, IR, A, B, ALU, flags and OUT. Latches halt after HLT.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_en          clock enable; 0 freezes ring/halt and forces controls to 0
//   i_lda..i_out  decoder one-hots, active-high
//   i_low_halt    decoder halt, active-low
//   o_cp..o_lf    control strobes, active-high
//   o_alu_op      000 add, 001 sub, 010 xor, 011 and, 100 or, 101 cmp (0 when o_eu=0)
//   o_t_state     one-hot ring, bit0=T1; 0 while halted
//   o_halted      set after HLT until reset
module controller_sequencer #(
    parameter int SKIP_NOP = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_lda,
    input  logic       i_add,
    input  logic       i_sub,
    input  logic       i_xor_ratna,
    input  logic       i_and_ratna,
    input  logic       i_or_ratna,
    input  logic       i_cmp_ratna,
    input  logic       i_out,
    input  logic       i_low_halt,
    output logic       o_cp,
    output logic       o_ep,
    output logic       o_lm,
    output logic       o_ce,
    output logic       o_li,
    output logic       o_ei,
    output logic       o_la,
    output logic       o_ea,
    output logic       o_lb,
    output logic       o_eu,
    output logic       o_lo,
    output logic       o_lf,
    output logic [2:0] o_alu_op,
    output logic [5:0] o_t_state,
    output logic       o_halted
);

    logic [5:0] r_t_state;
    logic       r_halted;

    logic w_t1, w_t2, w_t3, w_t4, w_t5, w_t6;
    logic w_act, w_skip;
    logic w_hlt, w_outi, w_ldai, w_alu, w_cmp, w_nop, w_mem, w_done;
    logic w_any_alu_bit, w_non_cmp_alu_bit;
    logic [2:0] w_alu_code;

    assign w_t1 = r_t_state[0];
    assign w_t2 = r_t_state[1];
    assign w_t3 = r_t_state[2];
    assign w_t4 = r_t_state[3];
    assign w_t5 = r_t_state[4];
    assign w_t6 = r_t_state[5];

    assign w_skip = (SKIP_NOP != 0);

    // Controls only drive while running: enable high, not in reset, not halted.
    assign w_act = i_en & ~i_rst & ~r_halted;

    // Priority resolution: halt > out > lda > alu group (add..cmp).
    assign w_non_cmp_alu_bit = i_add | i_sub | i_xor_ratna | i_and_ratna | i_or_ratna;
    assign w_any_alu_bit     = w_non_cmp_alu_bit | i_cmp_ratna;
    assign w_hlt  = ~i_low_halt;
    assign w_outi = ~w_hlt & i_out;
    assign w_ldai = ~w_hlt & ~i_out & i_lda;
    assign w_alu  = ~w_hlt & ~i_out & ~i_lda & w_any_alu_bit;
    assign w_cmp  = w_alu & ~w_non_cmp_alu_bit;
    assign w_nop  = ~w_hlt & ~i_out & ~i_lda & ~w_any_alu_bit;
    assign w_mem  = w_ldai | w_alu;

    always_comb begin
        w_alu_code = 3'b000;
        if (i_add)            w_alu_code = 3'b000;
        else if (i_sub)       w_alu_code = 3'b001;
        else if (i_xor_ratna) w_alu_code = 3'b010;
        else if (i_and_ratna) w_alu_code = 3'b011;
        else if (i_or_ratna)  w_alu_code = 3'b100;
        else                  w_alu_code = 3'b101;
    end

    assign o_ep = w_act & w_t1;
    assign o_lm = w_act & (w_t1 | (w_t4 & w_mem));
    assign o_cp = w_act & w_t2;
    assign o_ce = w_act & (w_t3 | (w_t5 & w_mem));
    assign o_li = w_act & w_t3;
    assign o_ei = w_act & w_t4 & w_mem;
    assign o_la = w_act & ((w_t5 & w_ldai) | (w_t6 & w_alu & ~w_cmp));
    assign o_ea = w_act & w_t4 & w_outi;
    assign o_lo = w_act & w_t4 & w_outi;
    assign o_lb = w_act & w_t5 & w_alu;
    assign o_eu = w_act & w_t6 & w_alu;
    assign o_lf = w_act & w_t6 & w_alu;
    assign o_alu_op = o_eu ? w_alu_code : 3'b000;

    assign o_t_state = r_t_state;
    assign o_halted  = r_halted;

    // Early return to T1 after the last active state. The NOP check in T3
    // relies on the decoder inputs already reflecting the incoming opcode.
    assign w_done = w_skip & ((w_t3 & w_nop)
                            | (w_t4 & (w_outi | w_nop))
                            | (w_t5 & (w_ldai | w_nop)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_t_state <= 6'b000001;
            r_halted  <= 1'b0;
        end else if (i_en && !r_halted) begin
            if (w_t4 && w_hlt) begin
                r_halted  <= 1'b1;
                r_t_state <= 6'b000000;
            end else if (w_t6 || w_done) begin
                r_t_state <= 6'b000001;
            end else begin
                r_t_state <= {r_t_state[4:0], r_t_state[5]};
            end
        end
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// tb/tb_controller_sequencer.sv - self-checking bench for controller_sequencer
module tb_controller_sequencer;

    localparam logic [14:0] CP = 15'h4000, EP = 15'h2000, LM = 15'h1000, CE = 15'h0800;
    localparam logic [14:0] LI = 15'h0400, EI = 15'h0200, LA = 15'h0100, EA = 15'h0080;
    localparam logic [14:0] LB = 15'h0040, EU = 15'h0020, LO = 15'h0010, LF = 15'h0008;

    // decode vector: bit0 lda,1 add,2 sub,3 xor,4 and,5 or,6 cmp,7 out,8 low_halt
    localparam logic [8:0] D_NOP = 9'h100, D_LDA = 9'h101, D_ADD = 9'h102, D_SUB = 9'h104;
    localparam logic [8:0] D_CMP = 9'h140, D_OUT = 9'h180, D_LDAOUT = 9'h181, D_HLT = 9'h000;

    // opcode ids used by the reference model
    localparam int OP_LDA = 0, OP_CMP = 6, OP_OUT = 7, OP_HLT = 8, OP_NOP = 9;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        en  [2];
    logic [8:0]  dec [2];
    logic [14:0] ctrl[2];
    logic [5:0]  ts  [2];
    logic        hl  [2];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic cp, ep, lm, ce, li, ei, la, ea, lb, eu, lo, lf, h;
        logic [2:0] op;
        logic [5:0] t;
        controller_sequencer #(.SKIP_NOP(k)) u_dut (
            .i_clk(clk), .i_rst(rst[k]), .i_en(en[k]),
            .i_lda(dec[k][0]), .i_add(dec[k][1]), .i_sub(dec[k][2]),
            .i_xor_ratna(dec[k][3]), .i_and_ratna(dec[k][4]), .i_or_ratna(dec[k][5]),
            .i_cmp_ratna(dec[k][6]), .i_out(dec[k][7]), .i_low_halt(dec[k][8]),
            .o_cp(cp), .o_ep(ep), .o_lm(lm), .o_ce(ce), .o_li(li), .o_ei(ei),
            .o_la(la), .o_ea(ea), .o_lb(lb), .o_eu(eu), .o_lo(lo), .o_lf(lf),
            .o_alu_op(op), .o_t_state(t), .o_halted(h)
        );
        assign ctrl[k] = {cp, ep, lm, ce, li, ei, la, ea, lb, eu, lo, lf, op};
        assign ts[k]   = t;
        assign hl[k]   = h;
    end

    // ---------------- reference model ----------------
    function automatic int resolve(logic [8:0] d);
        if (!d[8]) return OP_HLT;
        if (d[7])  return OP_OUT;
        for (int i = 0; i < 7; i++) if (d[i]) return i;
        return OP_NOP;
    endfunction

    function automatic int instr_len(int op, int skip);
        if (op == OP_HLT) return 4;
        if (skip == 0) return 6;
        case (op)
            OP_LDA:  return 5;
            OP_OUT:  return 4;
            OP_NOP:  return 3;
            default: return 6;
        endcase
    endfunction

    function automatic logic [14:0] exp_ctrl(int op, int t);
        bit is_alu;
        logic [14:0] code;
        is_alu = (op >= 1 && op <= OP_CMP);
        code = 15'(op - 1);
        case (t)
            1: return EP | LM;
            2: return CP;
            3: return CE | LI;
            4: if (op == OP_LDA || is_alu) return EI | LM;
               else if (op == OP_OUT) return EA | LO;
               else return 15'h0;
            5: if (op == OP_LDA) return CE | LA;
               else if (is_alu) return CE | LB;
               else return 15'h0;
            6: if (op == OP_CMP) return EU | LF | code;
               else if (is_alu) return EU | LA | LF | code;
               else return 15'h0;
            default: return 15'h0;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    function automatic void chk(string nm, int k, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endfunction

    task automatic check_all(int k, logic [5:0] ets, logic [14:0] ectl, logic eh, string nm);
        chk({nm, ".t_state"}, k, 16'(ts[k]), 16'(ets));
        chk({nm, ".ctrl"},    k, 16'(ctrl[k]), 16'(ectl));
        chk({nm, ".halted"},  k, 16'(hl[k]), 16'(eh));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int k);
        rst[k] = 1'b1;
        tick();
        rst[k] = 1'b0;
        en[k]  = 1'b1;
    endtask

    task automatic run_instr(int k, logic [8:0] d, bit gaps);
        int op, n;
        logic [5:0] oh;
        op = resolve(d);
        n  = instr_len(op, k);
        dec[k] = d;
        rst[k] = 1'b0;
        for (int t = 1; t <= n; t++) begin
            oh = 6'b000001 << (t - 1);
            if (gaps) begin
                while ($urandom_range(0, 5) == 0) begin
                    en[k] = 1'b0;
                    @(negedge clk);
                    check_all(k, oh, 15'h0, 1'b0, "gap");
                    tick();
                end
            end
            en[k] = 1'b1;
            @(negedge clk);
            check_all(k, oh, exp_ctrl(op, t), 1'b0, "step");
            tick();
        end
        if (op == OP_HLT) begin
            repeat (20) begin
                en[k]  = 1'($urandom_range(0, 1));
                dec[k] = 9'($urandom);
                @(negedge clk);
                check_all(k, 6'h00, 15'h0, 1'b1, "halt");
                tick();
            end
            rst[k] = 1'b1;
            en[k]  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_rst.ctrl", k, 16'(ctrl[k]), 16'h0);
            tick();
            rst[k] = 1'b0;
            en[k]  = 1'b1;
        end
    endtask

    function automatic logic [8:0] rand_dec();
        logic [8:0] d;
        int sel;
        d[8] = ($urandom_range(0, 24) != 0);
        if ($urandom_range(0, 3) == 0) begin
            d[7:0] = 8'($urandom);
        end else begin
            sel = $urandom_range(0, 8);
            d[7:0] = (sel == 8) ? 8'h00 : (8'h01 << sel);
        end
        return d;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst;
        logic        en;
        logic [8:0]  dec;
        logic [5:0]  ts;
        logic [14:0] ctl;
        logic        h;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic e, logic [8:0] d, logic [5:0] t, logic [14:0] c, logic h);
        vec_t v;
        v.rst = r; v.en = e; v.dec = d; v.ts = t; v.ctl = c; v.h = h;
        tbl.push_back(v);
    endfunction

    function automatic void add_fetch(logic [8:0] d);
        add(0, 1, d, 6'h01, EP | LM, 0);
        add(0, 1, d, 6'h02, CP, 0);
        add(0, 1, d, 6'h04, CE | LI, 0);
    endfunction

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        en[0]  = 1'b1; en[1]  = 1'b1;
        dec[0] = D_NOP; dec[1] = D_NOP;

        // LDA
        add_fetch(D_LDA);
        add(0, 1, D_LDA, 6'h08, EI | LM, 0);
        add(0, 1, D_LDA, 6'h10, CE | LA, 0);
        add(0, 1, D_LDA, 6'h20, 15'h0, 0);
        // SUB
        add_fetch(D_SUB);
        add(0, 1, D_SUB, 6'h08, EI | LM, 0);
        add(0, 1, D_SUB, 6'h10, CE | LB, 0);
        add(0, 1, D_SUB, 6'h20, EU | LA | LF | 15'd1, 0);
        // CMP
        add_fetch(D_CMP);
        add(0, 1, D_CMP, 6'h08, EI | LM, 0);
        add(0, 1, D_CMP, 6'h10, CE | LB, 0);
        add(0, 1, D_CMP, 6'h20, EU | LF | 15'd5, 0);
        // ADD with a 3-cycle enable gap in T5
        add_fetch(D_ADD);
        add(0, 1, D_ADD, 6'h08, EI | LM, 0);
        for (int i = 0; i < 3; i++) add(0, 0, D_ADD, 6'h10, 15'h0, 0);
        add(0, 1, D_ADD, 6'h10, CE | LB, 0);
        add(0, 1, D_ADD, 6'h20, EU | LA | LF, 0);
        // LDA and OUT together: OUT wins
        add_fetch(D_LDAOUT);
        add(0, 1, D_LDAOUT, 6'h08, EA | LO, 0);
        add(0, 1, D_LDAOUT, 6'h10, 15'h0, 0);
        add(0, 1, D_LDAOUT, 6'h20, 15'h0, 0);
        // HLT, 20 halted cycles with varying en/decode, then reset
        add_fetch(D_HLT);
        add(0, 1, D_HLT, 6'h08, 15'h0, 0);
        for (int i = 0; i < 20; i++)
            add(0, logic'(i % 3 != 0), (i % 2 == 0) ? 9'h1FF : D_LDA, 6'h00, 15'h0, 1);
        add(1, 0, D_NOP, 6'h00, 15'h0, 1);
        add(0, 1, D_NOP, 6'h01, EP | LM, 0);

        tick();

        // Reset: two cycles held, controls stay 0
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) chk("rst.ctrl", k, 16'(ctrl[k]), 16'h0);
            tick();
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_all(k, 6'h01, EP | LM, 1'b0, "post_rst");
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_all(k, 6'h02, CP, 1'b0, "post_rst2");
        tick();

        // Directed table on SKIP_NOP=0 instance
        do_reset(0);
        rst[1] = 1'b1;
        foreach (tbl[i]) begin
            rst[0] = tbl[i].rst;
            en[0]  = tbl[i].en;
            dec[0] = tbl[i].dec;
            @(negedge clk);
            check_all(0, tbl[i].ts, tbl[i].ctl, tbl[i].h, "tbl");
            tick();
        end
        do_reset(0);

        // SKIP_NOP=1: short instructions return straight to T1
        do_reset(1);
        run_instr(1, D_OUT, 1'b0);
        run_instr(1, D_NOP, 1'b0);
        run_instr(1, D_LDA, 1'b0);
        run_instr(1, D_CMP, 1'b0);
        run_instr(1, D_HLT, 1'b0);
        @(negedge clk);
        check_all(1, 6'h01, EP | LM, 1'b0, "skip_end");
        tick();
        do_reset(1);

        // Randomized stream against the model, both variants
        for (int k = 0; k < 2; k++) begin
            do_reset(k);
            for (int i = 0; i < 250; i++) run_instr(k, rand_dec(), 1'b1);
            dec[k] = D_NOP;
            @(negedge clk);
            check_all(k, 6'h01, EP | LM, 1'b0, "rand_end");
            tick();
            rst[k] = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
